// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop input synchronizer, mid-bit sampling,
// optional parity, 1-2 stop bits and a valid/ready output holding register.
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 100,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] dt,
  output logic                 dt_valid,
  input  logic                 dt_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_T = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] LAST_T = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_D = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_S = IW'(STOP_BITS - 1);
  localparam logic          ODD    = (PARITY_MODE == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, REARM} state_e;

  state_e                 state_q, state_d;
  logic                   rx_meta_q, rxs_q;
  logic [TW-1:0]          timer_q, timer_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic                   ferr_q, ferr_d, perr_q, perr_d;
  logic                   commit, ferr_fin, bit_tick;
  logic [DATA_BITS-1:0]   dt_q;
  logic                   dt_valid_q, frame_err_q, parity_err_q, overrun_q;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= IDLE;
      timer_q   <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

  assign bit_tick = (timer_q == LAST_T);
  assign ferr_fin = ferr_q | ~rxs_q;

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    idx_d   = idx_q;
    sh_d    = sh_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          idx_d   = '0;
          ferr_d  = 1'b0;
          perr_d  = 1'b0;
        end
      end
      START: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == HALF_T) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = rxs_q ? IDLE : DATA;
        end
      end
      DATA: begin
        timer_d = timer_q + 1'b1;
        if (bit_tick) begin
          timer_d = '0;
          sh_d    = {rxs_q, sh_q[DATA_BITS-1:1]};
          if (idx_q == LAST_D) begin
            idx_d   = '0;
            state_d = (PARITY_MODE != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        timer_d = timer_q + 1'b1;
        if (bit_tick) begin
          timer_d = '0;
          perr_d  = ^sh_q ^ rxs_q ^ ODD;
          state_d = STOP;
        end
      end
      STOP: begin
        timer_d = timer_q + 1'b1;
        if (bit_tick) begin
          timer_d = '0;
          ferr_d  = ferr_fin;
          if (idx_q == LAST_S) begin
            commit  = 1'b1;
            idx_d   = '0;
            state_d = ferr_fin ? REARM : IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      REARM: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  // A handshake on the commit cycle frees the register, so the new frame loads.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      dt_q         <= '0;
      dt_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (commit) begin
      if (!dt_valid_q || dt_ready) begin
        dt_q         <= sh_q;
        frame_err_q  <= ferr_fin;
        parity_err_q <= perr_q;
        dt_valid_q   <= 1'b1;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (dt_valid_q && dt_ready) begin
      dt_valid_q <= 1'b0;
    end
  end

  assign dt         = dt_q;
  assign dt_valid   = dt_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter CLKS_PER_BIT, default 100: CLOCK cycles per serial bit; legal range 4 or more.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY_MODE, default 0: parity mode; 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1: stop bits expected per frame; legal values 1 or 2.
REQ-005 CLOCK  in  1  single clock; all state updates on its rising edge.
REQ-006 RESET  in  1  reset; synchronous and active-high.
REQ-007 RX  in  1  asynchronous serial line; idle high.
REQ-008 dt  out  DATA_BITS  last committed frame's data, LSB = first received bit.
REQ-009 dt_valid  out  1  dt holds an unconsumed frame.
REQ-010 dt_ready  in  1  consumer accepts dt when high together with dt_valid.
REQ-011 frame_err  out  1  at least one stop bit of the frame in dt sampled low.
REQ-012 parity_err  out  1  parity check failed for the frame in dt; always 0 when PARITY_MODE=0.
REQ-013 overrun  out  1  sticky; a completed frame was discarded because dt was unconsumed.
REQ-014 busy  out  1  receiver is not in IDLE.

Function
REQ-015 RX SHALL pass through a 2-flop synchronizer reset to 1; all decisions use the synchronized value (rxs), 2-cycle input latency.
REQ-016 States SHALL be IDLE, START, DATA, PARITY, STOP, REARM; busy = (state != IDLE).
REQ-017 IDLE: first cycle rxs=0 (t0) -> START with bit timer cleared; rxs=1 -> stay.
REQ-018 START: sample rxs at t0 + CLKS_PER_BIT/2 (integer division); 1 -> IDLE with no output change (glitch rejected); 0 -> DATA, bit index 0, timer cleared.
REQ-019 DATA: data bit i SHALL be sampled at t0 + CLKS_PER_BIT/2 + (i+1)*CLKS_PER_BIT, stored LSB first; after bit DATA_BITS-1 -> PARITY if PARITY_MODE!=0, else STOP.
REQ-020 PARITY: one bit sampled one bit period after the last data bit; even mode error when XOR(data, parity bit)=1; odd mode error when it is 0.
REQ-021 STOP: STOP_BITS samples, one bit period apart; any sample 0 sets the frame's frame error.
REQ-022 Commit SHALL occur on the cycle of the final stop sample; the next state is IDLE when no frame error, else REARM.
REQ-023 REARM: wait for rxs=1 (break/stuck-low line), then -> IDLE; a falling edge is not accepted while in REARM.
REQ-024 On commit with dt_valid=0, or with dt_valid=1 and dt_ready=1: dt, frame_err, parity_err load the new frame; dt_valid=1 on the next edge.
REQ-025 On commit with dt_valid=1 and dt_ready=0: new frame discarded; dt/frame_err/parity_err unchanged; overrun set to 1.
REQ-026 Handshake (dt_valid & dt_ready) without commit SHALL clear dt_valid on the next edge; dt and error flags hold their values.
REQ-027 Errored frames (frame_err and/or parity_err) SHALL still be delivered through dt/dt_valid.
REQ-028 overrun SHALL clear only on RESET.
REQ-029 Bit timer width SHALL be $clog2(CLKS_PER_BIT)+1; timer and bit index SHALL not wrap within a frame.

Reset
REQ-030 RESET high SHALL force, on the next edge: state IDLE, synchronizer flops 1, dt=0, dt_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, timer and bit index 0.
REQ-031 RESET mid-frame SHALL abort the frame with no commit; reception restarts only on a new falling edge after RESET deasserts.
REQ-032 RESET SHALL take priority over commit and handshake in the same cycle.

Verification (CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1 unless noted)
REQ-033 PARITY_MODE=0, send 0xA5, dt_ready=0 -> dt=8'hA5, dt_valid=1 one cycle after the stop sample, frame_err=0, parity_err=0, overrun=0.
REQ-034 RX low for 4 cycles, then high -> busy pulses, dt_valid stays 0, state returns to IDLE.
REQ-035 PARITY_MODE=1, send 0x03 with parity bit 1 -> dt=8'h03, parity_err=1; repeat with parity bit 0 -> parity_err=0.
REQ-036 Send 0x55 with stop bit 0, RX held low 40 bit periods, then high -> one frame, dt=8'h55, frame_err=1; no further frame until RX rises and a new start bit arrives.
REQ-037 Two back-to-back frames 0x11, 0x22 with dt_ready=0 -> dt=8'h11, overrun=1; repeat with dt_ready=1 on the second commit cycle -> dt=8'h22, dt_valid stays 1, overrun=0.
REQ-038 RESET asserted during data bit 3 -> all outputs 0 on the next edge; the following clean frame 0x3C is received correctly.
